lsu_r0: RTL

Load/store initiator that sits between the pipeline's memory stage and the byte-lane data RAM. It accepts one load or store request at a time over a valid/ready handshake and drives the RAM's address, data, write-enable, size and sign controls. For loads it waits the RAM read latency and captures the extended read data. It returns a single response per request, carrying an optional misalignment error.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_align_chk_r0.sv | 14 +
 rtl/lsu_r0.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store initiator: FSM states and RAM size codes.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/lsu_align_chk_r0.sv
// Natural-alignment check for a request: halves on even bytes, words on 4-byte boundaries.
module lsu_align_chk_r0
   import lsu_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic       misaligned
);

   // size[1] covers both 10 and 11, which are both treated as a word
   assign misaligned = ((size == SIZE_HALF) && addr_lo[0]) ||
                       (size[1] && (addr_lo != 2'b00));

endmodule

// File: rtl/lsu_r0.sv
// Load/store initiator between the memory stage and the byte-lane data RAM, one request at a time.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word requests with rsp_err.
module lsu_r0
   import lsu_pkg::*;
#(
   parameter int BIT_WIDTH    = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [BIT_WIDTH-1:0]  req_wdata,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [BIT_WIDTH-1:0]  rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [BIT_WIDTH-1:0]  mem_data,
   output logic                  mem_wren,
   output logic                  mem_isSigned,
   output logic [1:0]            mem_dataSize,
   input  logic [BIT_WIDTH-1:0]  mem_q
);

   localparam int CW = $clog2(READ_LATENCY + 1);

   lsu_state_e            state_q, state_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BIT_WIDTH-1:0]  wdata_q, wdata_d;
   logic [1:0]            size_q, size_d;
   logic                  signed_q, signed_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0]  rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  misal;

`ifdef MEM_ALIGN_CHECK_EN
   lsu_align_chk_r0 u_align_chk (
      .size       (req_size),
      .addr_lo    (req_addr[1:0]),
      .misaligned (misal)
   );
`else
   assign misal = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_valid) state_d = misal ? ST_RESP : ST_ISSUE;
         ST_ISSUE: state_d = we_q ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (cnt_q == CW'(1)) state_d = ST_RESP;
         ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // mem_wren decodes the state register directly so reset drops it without waiting for an edge
   always_comb begin
      req_ready    = (state_q == ST_IDLE);
      rsp_valid    = (state_q == ST_RESP);
      mem_wren     = (state_q == ST_ISSUE) && we_q;
      mem_addr     = addr_q;
      mem_data     = wdata_q;
      mem_dataSize = size_q;
      mem_isSigned = signed_q;
      rsp_rdata    = rdata_q;
      rsp_err      = err_q;
   end

   always_comb begin
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      signed_d = signed_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: if (req_valid) begin
            we_d     = req_we;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            size_d   = req_size[1] ? SIZE_WORD : req_size;
            signed_d = req_signed;
            rdata_d  = '0;
            err_d    = misal;
         end
         ST_ISSUE: if (!we_q) cnt_d = CW'(READ_LATENCY);
         ST_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) rdata_d = mem_q;
         end
         ST_RESP: if (rsp_ready) err_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule
